// File: rtl/evr_action_pkg.sv
// Shared constants and types for the EVR action-RAM loader.
package evr_action_pkg;

    typedef enum logic [1:0] {
        OP_WRITE = 2'b00,
        OP_CLEAR = 2'b01,
        OP_FILL  = 2'b10,
        OP_ACK   = 2'b11
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE,
        SINGLE,
        SWEEP
    } state_t;

    localparam int unsigned ACTION_RAM_DEPTH = 256;
    localparam int unsigned STATUS_BUSY      = 31;
    localparam int unsigned STATUS_OVERRUN   = 30;
    localparam logic [7:0]  LAST_ADDR        = 8'(ACTION_RAM_DEPTH - 1);

endpackage

// File: rtl/evr_action_loader_if.sv
// Command, status and action-RAM write signals of the loader, bundled for
// wrappers and benches; the loader itself keeps the EVR core's flat port names.
interface evr_action_loader_if #(
    parameter int ACTION_RAM_WIDTH = 8
);
    logic                        csr_strobe;
    logic [31:0]                 gpio_out;
    logic [31:0]                 status;
    logic                        action_we;
    logic [7:0]                  action_addr;
    logic [ACTION_RAM_WIDTH-1:0] action_data;

    modport master (
        output csr_strobe, gpio_out,
        input  status, action_we, action_addr, action_data
    );

    modport slave (
        input  csr_strobe, gpio_out,
        output status, action_we, action_addr, action_data
    );
endinterface

// File: rtl/evr_action_loader.sv
// Loads the EVR action RAM from CSR commands: single writes, CLEAR/FILL sweeps
// over all entries, and an automatic CLEAR sweep after every reset.
module evr_action_loader
    import evr_action_pkg::*;
#(
    parameter int ACTION_RAM_WIDTH = 8
) (
    input  logic                        sysClk,
    input  logic                        sysResetN,
    input  logic                        sysCsrStrobe,
    input  logic [31:0]                 GPIO_OUT,
    output logic [31:0]                 status,
    output logic                        sysActionWriteEnable,
    output logic [7:0]                  sysActionAddress,
    output logic [ACTION_RAM_WIDTH-1:0] sysActionData
);

    state_t  state;
    logic    overrun;
    logic    busy;
    opcode_t op;
    logic    unused_bits;

    assign busy        = (state != IDLE);
    assign op          = opcode_t'(GPIO_OUT[31:30]);
    assign unused_bits = &{1'b0, GPIO_OUT};

    always_comb begin
        status                 = '0;
        status[STATUS_BUSY]    = busy;
        status[STATUS_OVERRUN] = overrun;
        status[7:0]            = sysActionAddress;
    end

    always_ff @(posedge sysClk or negedge sysResetN) begin
        if (!sysResetN) begin
            // Reset parks in SWEEP with WE low: the armed initial CLEAR.
            state                <= SWEEP;
            sysActionWriteEnable <= 1'b0;
            sysActionAddress     <= '0;
            sysActionData        <= '0;
            overrun              <= 1'b0;
        end else begin
            if (sysCsrStrobe) begin
                if (op == OP_ACK) begin
                    overrun <= 1'b0;
                end else if (busy) begin
                    overrun <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (sysCsrStrobe) begin
                        case (op)
                            OP_WRITE: begin
                                state                <= SINGLE;
                                sysActionWriteEnable <= 1'b1;
                                sysActionAddress     <= GPIO_OUT[23:16];
                                sysActionData        <= GPIO_OUT[ACTION_RAM_WIDTH-1:0];
                            end
                            OP_CLEAR: begin
                                state                <= SWEEP;
                                sysActionWriteEnable <= 1'b1;
                                sysActionAddress     <= '0;
                                sysActionData        <= '0;
                            end
                            OP_FILL: begin
                                state                <= SWEEP;
                                sysActionWriteEnable <= 1'b1;
                                sysActionAddress     <= '0;
                                sysActionData        <= GPIO_OUT[ACTION_RAM_WIDTH-1:0];
                            end
                            default: ;
                        endcase
                    end
                end
                SINGLE: begin
                    state                <= IDLE;
                    sysActionWriteEnable <= 1'b0;
                end
                SWEEP: begin
                    if (!sysActionWriteEnable) begin
                        sysActionWriteEnable <= 1'b1;
                        sysActionAddress     <= '0;
                    end else if (sysActionAddress == LAST_ADDR) begin
                        state                <= IDLE;
                        sysActionWriteEnable <= 1'b0;
                    end else begin
                        sysActionAddress <= sysActionAddress + 8'd1;
                    end
                end
                default: begin
                    state                <= IDLE;
                    sysActionWriteEnable <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_evr_action_loader.sv
// Scoreboard bench for evr_action_loader: expected RAM writes are queued as
// commands are issued and popped by a monitor whenever the loader writes.
module tb_evr_action_loader;

    localparam int W = 8;

    typedef struct {
        logic [7:0]   addr;
        logic [W-1:0] data;
    } wr_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;
    int   writes;
    wr_t  exp_q[$];

    evr_action_loader_if #(.ACTION_RAM_WIDTH(W)) bus ();

    evr_action_loader #(.ACTION_RAM_WIDTH(W)) dut (
        .sysClk               (clk),
        .sysResetN            (rst_n),
        .sysCsrStrobe         (bus.csr_strobe),
        .GPIO_OUT             (bus.gpio_out),
        .status               (bus.status),
        .sysActionWriteEnable (bus.action_we),
        .sysActionAddress     (bus.action_addr),
        .sysActionData        (bus.action_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Every write the loader issues must match the head of the expected queue.
    always @(negedge clk) begin
        if (rst_n && bus.action_we) begin
            wr_t e;
            writes++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write: got addr=%02h data=%02h, required no write",
                         bus.action_addr, bus.action_data);
            end else begin
                e = exp_q.pop_front();
                if (bus.action_addr !== e.addr || bus.action_data !== e.data ||
                    bus.status[7:0] !== e.addr) begin
                    failures++;
                    $display("FAIL ram_write: got addr=%02h data=%02h status_addr=%02h, required addr=%02h data=%02h",
                             bus.action_addr, bus.action_data, bus.status[7:0], e.addr, e.data);
                end
            end
        end
    end

    task automatic push_sweep(input logic [W-1:0] d, input int count);
        for (int i = 0; i < count; i++) begin
            wr_t e;
            e.addr = 8'(i);
            e.data = d;
            exp_q.push_back(e);
        end
    endtask

    task automatic push_one(input logic [7:0] a, input logic [W-1:0] d);
        wr_t e;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; holds the strobe for exactly one rising edge.
    task automatic drive_strobe(input logic [1:0] op, input logic [7:0] code, input logic [7:0] dat);
        bus.gpio_out   = {op, 6'h2A, code, 8'hC3, dat};
        bus.csr_strobe = 1'b1;
        @(negedge clk);
        bus.csr_strobe = 1'b0;
        bus.gpio_out   = 32'hFFFF_FFFF;
    endtask

    task automatic wait_idle(input int limit, input string name);
        for (int i = 0; i < limit && bus.status[31] !== 1'b0; i++) @(negedge clk);
        checks++;
        if (bus.status[31] !== 1'b0) begin
            failures++;
            $display("FAIL %s_timeout: busy=%b after %0d cycles, required 0", name, bus.status[31], limit);
        end
    endtask

    task automatic wait_addr(input logic [7:0] target, input int limit, input string name);
        for (int i = 0; i < limit; i++) begin
            if (bus.action_we === 1'b1 && bus.action_addr === target) break;
            @(negedge clk);
        end
        checks++;
        if (!(bus.action_we === 1'b1 && bus.action_addr === target)) begin
            failures++;
            $display("FAIL %s_timeout: addr=%02h we=%b, required write at %02h", name,
                     bus.action_addr, bus.action_we, target);
        end
    endtask

    task automatic test_reset();
        int w0;
        rst_n          = 1'b0;
        bus.csr_strobe = 1'b0;
        bus.gpio_out   = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (bus.action_we !== 1'b0 || bus.action_addr !== 8'h00 || bus.action_data !== '0 ||
            bus.status[31] !== 1'b1 || bus.status[30] !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got we=%b addr=%02h data=%02h busy=%b ovr=%b, required 0 00 00 1 0",
                     bus.action_we, bus.action_addr, bus.action_data, bus.status[31], bus.status[30]);
        end
        w0 = writes;
        push_sweep('0, 256);
        #2 rst_n = 1'b1;
        wait_idle(300, "init_sweep");
        checks++;
        if (writes - w0 !== 256 || bus.action_we !== 1'b0 || bus.action_addr !== 8'hFF) begin
            failures++;
            $display("FAIL init_sweep: got writes=%0d we=%b addr=%02h, required 256 0 ff",
                     writes - w0, bus.action_we, bus.action_addr);
        end
    endtask

    task automatic test_single_write();
        int w0;
        w0 = writes;
        push_one(8'h7D, 8'h5A);
        drive_strobe(2'b00, 8'h7D, 8'h5A);
        checks++;
        if (bus.status[31] !== 1'b1 || bus.action_we !== 1'b1) begin
            failures++;
            $display("FAIL single_busy: got busy=%b we=%b, required 1 1", bus.status[31], bus.action_we);
        end
        @(negedge clk);
        checks++;
        if (bus.status[31] !== 1'b0 || bus.action_we !== 1'b0 || bus.action_addr !== 8'h7D ||
            bus.action_data !== 8'h5A || bus.status[30] !== 1'b0 || writes - w0 !== 1) begin
            failures++;
            $display("FAIL single_done: got busy=%b we=%b addr=%02h data=%02h ovr=%b writes=%0d, required 0 0 7d 5a 0 1",
                     bus.status[31], bus.action_we, bus.action_addr, bus.action_data, bus.status[30], writes - w0);
        end
    endtask

    task automatic test_fill_overrun();
        push_sweep(8'hA5, 256);
        drive_strobe(2'b10, 8'h00, 8'hA5);
        wait_addr(8'd100, 300, "fill_100");
        drive_strobe(2'b00, 8'h11, 8'h22);
        checks++;
        if (bus.status[30] !== 1'b1 || bus.status[31] !== 1'b1 || bus.action_we !== 1'b1) begin
            failures++;
            $display("FAIL fill_overrun: got ovr=%b busy=%b we=%b, required 1 1 1",
                     bus.status[30], bus.status[31], bus.action_we);
        end
        wait_idle(300, "fill_sweep");
        checks++;
        if (bus.status[30] !== 1'b1) begin
            failures++;
            $display("FAIL overrun_sticky: got ovr=%b, required 1", bus.status[30]);
        end
        drive_strobe(2'b11, 8'h00, 8'h00);
        checks++;
        if (bus.status[30] !== 1'b0 || bus.action_we !== 1'b0 || bus.action_addr !== 8'hFF ||
            bus.action_data !== 8'hA5) begin
            failures++;
            $display("FAIL ack_clear: got ovr=%b we=%b addr=%02h data=%02h, required 0 0 ff a5",
                     bus.status[30], bus.action_we, bus.action_addr, bus.action_data);
        end
    endtask

    task automatic test_last_write_boundary();
        push_sweep('0, 256);
        drive_strobe(2'b01, 8'h00, 8'h99);
        wait_addr(8'hFF, 300, "clear_255");
        drive_strobe(2'b00, 8'h33, 8'h44);
        checks++;
        if (bus.status[30] !== 1'b1 || bus.status[31] !== 1'b0 || bus.action_we !== 1'b0) begin
            failures++;
            $display("FAIL last_write_reject: got ovr=%b busy=%b we=%b, required 1 0 0",
                     bus.status[30], bus.status[31], bus.action_we);
        end
        push_one(8'h34, 8'h55);
        drive_strobe(2'b00, 8'h34, 8'h55);
        checks++;
        if (bus.status[31] !== 1'b1 || bus.action_we !== 1'b1) begin
            failures++;
            $display("FAIL after_sweep_write: got busy=%b we=%b, required 1 1", bus.status[31], bus.action_we);
        end
        @(negedge clk);
        drive_strobe(2'b11, 8'h00, 8'h00);
    endtask

    task automatic test_reset_mid_sweep();
        push_sweep('0, 8'h41);
        drive_strobe(2'b01, 8'h00, 8'h00);
        wait_addr(8'h10, 100, "clear_10");
        drive_strobe(2'b00, 8'h66, 8'h77);
        wait_addr(8'h40, 100, "clear_40");
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.action_we !== 1'b0 || bus.action_addr !== 8'h00 || bus.status[30] !== 1'b0 ||
            bus.status[31] !== 1'b1 || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL mid_reset: got we=%b addr=%02h ovr=%b busy=%b pending=%0d, required 0 00 0 1 0",
                     bus.action_we, bus.action_addr, bus.status[30], bus.status[31], exp_q.size());
        end
        push_sweep('0, 256);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_idle(300, "restart_sweep");
        checks++;
        if (bus.status[30] !== 1'b0 || bus.action_addr !== 8'hFF || exp_q.size() !== 0) begin
            failures++;
            $display("FAIL restart_sweep: got ovr=%b addr=%02h pending=%0d, required 0 ff 0",
                     bus.status[30], bus.action_addr, exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        drive_strobe(2'b11, 8'h00, 8'h00);
        checks++;
        if (bus.status[31] !== 1'b0 || bus.action_we !== 1'b0) begin
            failures++;
            $display("FAIL ack_idle: got busy=%b we=%b, required 0 0", bus.status[31], bus.action_we);
        end
        push_one(8'h5C, 8'h3C);
        drive_strobe(2'b00, 8'h5C, 8'h3C);
        checks++;
        if (bus.status[31] !== 1'b1 || bus.action_we !== 1'b1) begin
            failures++;
            $display("FAIL b2b_write: got busy=%b we=%b, required 1 1", bus.status[31], bus.action_we);
        end
        @(negedge clk);
        checks++;
        if (bus.status[31] !== 1'b0 || bus.status[30] !== 1'b0) begin
            failures++;
            $display("FAIL b2b_done: got busy=%b ovr=%b, required 0 0", bus.status[31], bus.status[30]);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        writes   = 0;
        test_reset();
        test_single_write();
        test_fill_overrun();
        test_last_write_boundary();
        test_reset_mid_sweep();
        test_back_to_back();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            failures++;
            $display("FAIL scoreboard_drain: got pending=%0d, required 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
